// File: rtl/cia_host_arbiter_pkg.sv
// Shared types and constants for the CIA host/bus register-file arbiter.
// Contents: arbiter FSM state enum, latched host request struct, the number
// of clk cycles a host access occupies, and a saturating 8-bit increment.
package cia_host_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    ACK    = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
  } host_req_t;

  // SETUP + STROBE + ACK
  localparam int HOST_ACCESS_CYCLES = 3;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cia_phi2_window.sv
// phi2 phase measurement and host access window.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   phi2              bus clock, already synchronised to clk
//   phi2_q            phi2 registered (the phase the arbiter works from)
//   phi2_up, phi2_dn  one-cycle pulses in the first high / first low cycle of phi2_q
//   window            a complete host access plus guard cycles still fits in
//                     the current low phase, judged by the previous low length
module cia_phi2_window
  import cia_host_arbiter_pkg::*;
#(
  parameter int GUARD_CYCLES = 2,
  parameter int MIN_LOW      = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic phi2,
  output logic phi2_q,
  output logic phi2_up,
  output logic phi2_dn,
  output logic window
);

  logic       phi2_qq;
  logic [7:0] low_cnt;
  logic [7:0] last_low;

  assign phi2_up = phi2_q & ~phi2_qq;
  assign phi2_dn = ~phi2_q & phi2_qq;

  // low_cnt is computed one cycle ahead from the raw phi2 so that it reads 0
  // in the first phi2_q-low cycle.  It stops advancing once phi2 goes high,
  // so in the phi2_up cycle it still holds the index of the last low cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phi2_q   <= 1'b0;
      phi2_qq  <= 1'b0;
      low_cnt  <= 8'd0;
      last_low <= 8'd0;
    end else begin
      phi2_q  <= phi2;
      phi2_qq <= phi2_q;
      if (!phi2) begin
        if (phi2_q) low_cnt <= 8'd0;
        else        low_cnt <= sat_inc(low_cnt);
      end
      if (phi2_up) last_low <= sat_inc(low_cnt);
    end
  end

  assign window = ~phi2_q
                & (int'(last_low) >= MIN_LOW)
                & ((int'(low_cnt) + HOST_ACCESS_CYCLES + GUARD_CYCLES) <= int'(last_low));

endmodule

// File: rtl/cia_host_arbiter.sv
// Arbitrates the CIA register file between the 65xx bus and an internal host
// port.  The bus owns the phi2-high phase; host accesses (SETUP, STROBE, ACK)
// are slotted into the phi2-low phase when the measured window allows.
// Drives one address/strobe/commit interface to the register sub-blocks.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   phi2, cs_n, r_w_n                bus phase, chip select, read/write
//   bus_addr, bus_wdata              bus address / write data
//   host_req/we/addr/wdata           host request (held until host_ack)
//   host_ack, host_rdata, host_err   completion pulse, read data, timeout flag
//   host_busy                        host transaction accepted, not yet acked
//   core_addr/wdata/rd/we/commit     register file access interface
//   core_rdata                       addressed register value
// Handshake: host_req is a level held until the one-cycle host_ack; the host
// may change host_we/addr/wdata only after host_ack.  A host_req still high
// in the cycle after host_ack starts a new transaction.
// Build option: define CIA_HOST_ARB_TIMEOUT_EN to complete a request with
// host_err after TIMEOUT_PHI2 phi2 periods without an access window.
module cia_host_arbiter
  import cia_host_arbiter_pkg::*;
#(
  parameter int GUARD_CYCLES = 2,
  parameter int MIN_LOW      = 5,
  parameter int TIMEOUT_PHI2 = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       phi2,
  input  logic       cs_n,
  input  logic       r_w_n,
  input  logic [3:0] bus_addr,
  input  logic [7:0] bus_wdata,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [3:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       host_ack,
  output logic [7:0] host_rdata,
  output logic       host_err,
  output logic       host_busy,
  output logic [3:0] core_addr,
  output logic [7:0] core_wdata,
  output logic       core_rd,
  output logic       core_we,
  output logic       core_commit,
  input  logic [7:0] core_rdata
);

  logic       phi2_q;
  logic       phi2_up;
  logic       phi2_dn;
  logic       window;
  arb_state_t state;
  arb_state_t state_nx;
  host_req_t  lat;
  logic       busy_r;
  logic       bus_we_q;
  logic [7:0] rdata_r;
  logic       timeout_hit;

  cia_phi2_window #(
    .GUARD_CYCLES (GUARD_CYCLES),
    .MIN_LOW      (MIN_LOW)
  ) u_window (
    .clk     (clk),
    .rst_n   (rst_n),
    .phi2    (phi2),
    .phi2_q  (phi2_q),
    .phi2_up (phi2_up),
    .phi2_dn (phi2_dn),
    .window  (window)
  );

`ifdef CIA_HOST_ARB_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       err_l;

  // Counts phi2 periods while a request waits in IDLE (including after an
  // aborted SETUP); cleared whenever the request drops or completes.
  assign timeout_hit = (state == IDLE) & host_req & phi2_up
                     & ((int'(to_cnt) + 1) >= TIMEOUT_PHI2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= 8'd0;
      err_l  <= 1'b0;
    end else begin
      err_l <= (state == IDLE) && (state_nx == ACK);
      if (!host_req || state == ACK || timeout_hit) to_cnt <= 8'd0;
      else if (state == IDLE && phi2_up)           to_cnt <= to_cnt + 8'd1;
    end
  end

  assign host_err = (state == ACK) & err_l;
`else
  logic unused_phi2_up;
  assign unused_phi2_up = phi2_up;
  assign timeout_hit    = 1'b0;
  assign host_err       = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (host_req && window) state_nx = SETUP;
        else if (timeout_hit)   state_nx = ACK;
      end
      // phi2 rising before the strobe means the window was misjudged; drop
      // back and retry later rather than collide with the bus.
      SETUP:   state_nx = phi2_q ? IDLE : STROBE;
      STROBE:  state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lat      <= '0;
      busy_r   <= 1'b0;
      bus_we_q <= 1'b0;
      rdata_r  <= 8'd0;
    end else begin
      state    <= state_nx;
      bus_we_q <= phi2_q & ~cs_n & ~r_w_n;
      if (state == IDLE && state_nx == SETUP) begin
        lat.we    <= host_we;
        lat.addr  <= host_addr;
        lat.wdata <= host_wdata;
      end
      if (state_nx == ACK)                         busy_r <= 1'b0;
      else if (state == IDLE && state_nx == SETUP) busy_r <= 1'b1;
      if (state == STROBE)                         rdata_r <= core_rdata;
      else if (state == IDLE && state_nx == ACK)   rdata_r <= 8'hFF;
    end
  end

  // The host owns the core interface in STROBE (which always completes) and
  // in SETUP/ACK while phi2_q is low; otherwise the bus decode passes through.
  // Bus strobes need phi2_q high or a phi2_dn commit, so they never coincide
  // with the host STROBE cycle.
  always_comb begin
    core_addr   = bus_addr;
    core_wdata  = bus_wdata;
    core_rd     = 1'b0;
    core_we     = 1'b0;
    core_commit = 1'b0;
    if (state == STROBE) begin
      core_addr   = lat.addr;
      core_wdata  = lat.wdata;
      core_rd     = ~lat.we;
      core_we     = lat.we;
      core_commit = lat.we;
    end else if (state != IDLE && !phi2_q) begin
      core_addr  = lat.addr;
      core_wdata = lat.wdata;
    end else begin
      core_rd     = phi2_q & ~cs_n & r_w_n;
      core_we     = phi2_q & ~cs_n & ~r_w_n;
      core_commit = phi2_dn & bus_we_q;
    end
    // Bus address/data are passed through combinationally; force them low
    // while reset is held so every output is 0 during reset.
    if (!rst_n) begin
      core_addr  = 4'd0;
      core_wdata = 8'd0;
    end
  end

  assign host_ack   = (state == ACK);
  assign host_busy  = busy_r;
  assign host_rdata = rdata_r;

endmodule

// File: tb/tb_cia_host_arbiter.sv
module tb_cia_host_arbiter;

`ifdef CIA_HOST_ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       phi2;
  logic       cs_n;
  logic       r_w_n;
  logic [3:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       host_req;
  logic       host_we;
  logic [3:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic       host_err;
  logic       host_busy;
  logic [3:0] core_addr;
  logic [7:0] core_wdata;
  logic       core_rd;
  logic       core_we;
  logic       core_commit;
  logic [7:0] core_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  cia_host_arbiter #(
    .GUARD_CYCLES (2),
    .MIN_LOW      (5),
    .TIMEOUT_PHI2 (TB_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .phi2        (phi2),
    .cs_n        (cs_n),
    .r_w_n       (r_w_n),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .host_err    (host_err),
    .host_busy   (host_busy),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_rd     (core_rd),
    .core_we     (core_we),
    .core_commit (core_commit),
    .core_rdata  (core_rdata)
  );

  // clock / reset / phi2 generation
  always #5 clk = ~clk;

  int hi_len = 10;
  int lo_len = 10;
  int ph_cnt = 0;

  initial begin
    phi2 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph_cnt++;
      if (phi2 && ph_cnt >= hi_len) begin
        phi2   = 1'b0;
        ph_cnt = 0;
      end else if (!phi2 && ph_cnt >= lo_len) begin
        phi2   = 1'b1;
        ph_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // reference phase: ph_q follows phi2 one clk later, lo_idx counts the
  // cycles of the current ph_q-low phase starting at 0
  logic ph_q   = 1'b0;
  int   lo_idx = 0;

  always @(posedge clk) begin
    ph_q <= phi2;
    if (!phi2) lo_idx <= ph_q ? 0 : lo_idx + 1;
  end

  // monitors: strobes seen in the low phase belong to the host
  int lo_strobes  = 0;
  int all_strobes = 0;
  int ack_cnt     = 0;

  always @(negedge clk) begin
    if (core_rd || core_we) all_strobes <= all_strobes + 1;
    if (!ph_q && (core_rd || core_we)) lo_strobes <= lo_strobes + 1;
    if (host_ack) ack_cnt <= ack_cnt + 1;
  end

  // checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_lo(input int idx);
    int found = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!ph_q && lo_idx == idx) begin
        found = 1;
        break;
      end
    end
    check("wait_lo", 32'(found), 32'd1);
  endtask

  task automatic wait_hi(input int n);
    int found = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ph_q) begin
        found = 1;
        break;
      end
    end
    check("wait_hi", 32'(found), 32'd1);
    repeat (n) tick();
  endtask

  // called at the negedge of low index 0; the access must be accepted there
  task automatic host_access(input logic we, input logic [3:0] addr,
                             input logic [7:0] wdata, input logic [7:0] rd_exp);
    int s0;
    host_we    = we;
    host_addr  = addr;
    host_wdata = wdata;
    host_req   = 1'b1;
    if (!we) exp_q.push_back(rd_exp);
    s0 = lo_strobes;
    tick();
    check("setup_busy", 32'(host_busy), 32'd1);
    check("setup_nostrobe", 32'({core_rd, core_we}), 32'd0);
    check("setup_addr", 32'(core_addr), 32'(addr));
    tick();
    check("strobe_addr", 32'(core_addr), 32'(addr));
    check("strobe_rd", 32'(core_rd), 32'(!we));
    check("strobe_we", 32'(core_we), 32'(we));
    check("strobe_commit", 32'(core_commit), 32'(we));
    if (we) check("strobe_wdata", 32'(core_wdata), 32'(wdata));
    tick();
    check("ack", 32'(host_ack), 32'd1);
    check("ack_err", 32'(host_err), 32'd0);
    if (!we) check("ack_rdata", 32'(host_rdata), 32'(exp_q.pop_front()));
    host_req = 1'b0;
    tick();
    check("ack_pulse", 32'(host_ack), 32'd0);
    check("busy_clear", 32'(host_busy), 32'd0);
    check("one_strobe", lo_strobes - s0, 32'd1);
  endtask

  // a whole low phase (plus two high cycles) with no host activity
  task automatic quiet_phase(input string tag);
    int s0;
    int a0;
    wait_lo(0);
    s0 = lo_strobes;
    a0 = ack_cnt;
    repeat (12) tick();
    check({tag, "_no_strobe"}, lo_strobes - s0, 32'd0);
    check({tag, "_no_ack"}, ack_cnt - a0, 32'd0);
  endtask

  initial begin
    int s0;
    int a0;
    int ups;
    logic prev_ph;

    rst_n      = 1'b0;
    cs_n       = 1'b0;
    r_w_n      = 1'b1;
    bus_addr   = 4'hA;
    bus_wdata  = 8'h77;
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_addr  = 4'h0;
    host_wdata = 8'h00;
    core_rdata = 8'h00;

    // reset state
    repeat (3) tick();
    check("rst_core_addr", 32'(core_addr), 32'd0);
    check("rst_core_wdata", 32'(core_wdata), 32'd0);
    check("rst_strobes", 32'({core_rd, core_we, core_commit}), 32'd0);
    check("rst_host", 32'({host_ack, host_busy, host_err}), 32'd0);
    check("rst_rdata", 32'(host_rdata), 32'd0);

    // release in a high phase with a write request already pending:
    // the first low phase only measures, the access lands in the second
    wait_hi(1);
    rst_n      = 1'b1;
    cs_n       = 1'b1;
    bus_addr   = 4'h0;
    host_we    = 1'b1;
    host_addr  = 4'h4;
    host_wdata = 8'h5A;
    host_req   = 1'b1;
    quiet_phase("first_low");
    wait_lo(0);
    host_access(1'b1, 4'h4, 8'h5A, 8'h00);

    // host read with a single strobe
    wait_lo(0);
    core_rdata = 8'h81;
    host_access(1'b0, 4'hD, 8'h00, 8'h81);
    tick();
    check("rdata_hold", 32'(host_rdata), 32'h81);

    // request too late in the low phase waits for the next one
    wait_lo(6);
    host_we    = 1'b1;
    host_addr  = 4'h2;
    host_wdata = 8'hC3;
    host_req   = 1'b1;
    s0 = lo_strobes;
    a0 = ack_cnt;
    wait_lo(0);
    check("late_no_strobe", lo_strobes - s0, 32'd0);
    check("late_no_ack", ack_cnt - a0, 32'd0);
    host_access(1'b1, 4'h2, 8'hC3, 8'h00);

    // bus write during high with a concurrent host request
    wait_hi(2);
    cs_n       = 1'b0;
    r_w_n      = 1'b0;
    bus_addr   = 4'h6;
    bus_wdata  = 8'h33;
    host_we    = 1'b1;
    host_addr  = 4'h9;
    host_wdata = 8'h11;
    host_req   = 1'b1;
    tick();
    check("bus_we_level", 32'(core_we), 32'd1);
    check("bus_addr", 32'(core_addr), 32'h6);
    check("bus_wdata", 32'(core_wdata), 32'h33);
    check("bus_no_commit_high", 32'(core_commit), 32'd0);
    check("bus_no_host_ack", 32'(host_ack), 32'd0);
    wait_lo(0);
    check("bus_commit", 32'(core_commit), 32'd1);
    check("bus_commit_addr", 32'(core_addr), 32'h6);
    check("bus_we_low", 32'(core_we), 32'd0);
    cs_n  = 1'b1;
    r_w_n = 1'b1;
    host_access(1'b1, 4'h9, 8'h11, 8'h00);

    // reset during STROBE, request held through reset and restarted
    wait_lo(0);
    core_rdata = 8'h81;
    host_we    = 1'b0;
    host_addr  = 4'h3;
    host_req   = 1'b1;
    tick();
    tick();
    check("pre_reset_strobe", 32'(core_rd), 32'd1);
    a0 = ack_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_strobes", 32'({core_rd, core_we, core_commit}), 32'd0);
    check("mid_rst_core_addr", 32'(core_addr), 32'd0);
    check("mid_rst_host", 32'({host_ack, host_busy, host_err}), 32'd0);
    check("mid_rst_rdata", 32'(host_rdata), 32'd0);
    wait_hi(1);
    rst_n = 1'b1;
    check("mid_rst_no_ack", ack_cnt - a0, 32'd0);
    quiet_phase("post_rst_low");
    wait_lo(0);
    host_access(1'b0, 4'h3, 8'h00, 8'h81);

    // short low phase: never a window
    hi_len = 3;
    lo_len = 3;
    wait_hi(0);
    wait_lo(0);
    wait_hi(0);
    wait_lo(0);
    host_we   = 1'b0;
    host_addr = 4'h1;
    host_req  = 1'b1;
    s0 = all_strobes;
    ups = 0;
    prev_ph = ph_q;
`ifdef CIA_HOST_ARB_TIMEOUT_EN
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ph_q && !prev_ph) ups++;
      prev_ph = ph_q;
      if (host_ack) break;
    end
    check("to_ack", 32'(host_ack), 32'd1);
    check("to_err", 32'(host_err), 32'd1);
    check("to_rdata", 32'(host_rdata), 32'hFF);
    check("to_phi2_ups", ups, 32'd4);
    check("to_no_strobe", all_strobes - s0, 32'd0);
    host_req = 1'b0;
    tick();
    check("to_ack_pulse", 32'(host_ack), 32'd0);
`else
    a0 = ack_cnt;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ph_q && !prev_ph) ups++;
      prev_ph = ph_q;
    end
    check("short_phase_ups", 32'(ups > 5), 32'd1);
    check("short_no_ack", ack_cnt - a0, 32'd0);
    check("short_no_strobe", all_strobes - s0, 32'd0);
    check("short_err", 32'(host_err), 32'd0);
    host_req = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cia_host_arbiter.md
Name: cia_host_arbiter

Overview:
Shares the CIA register file between the 65xx bus and an FPGA-internal host port used for debug and configuration.
- Bus accesses own the phi2-high phase unconditionally.
- Host accesses are inserted only inside the phi2-low phase, using a window measured from the previous low phase.
- Produces the single address/strobe/commit interface that drives the register-owning sub-blocks in place of raw phi2/cs_n/r_w_n decoding.

Parameters:
GUARD_CYCLES, 2, minimum clk cycles left in the low phase after a host access completes.
MIN_LOW, 5, minimum measured low length (clk cycles) below which host accesses are never issued.
TIMEOUT_PHI2, 255, phi2 periods a host request may wait before error completion (optional feature only).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
phi2  in  1  bus clock, already synchronised to clk
cs_n  in  1  bus chip select
r_w_n  in  1  bus read/write
bus_addr  in  4  bus register address
bus_wdata  in  8  bus write data
host_req  in  1  host request, held until host_ack
host_we  in  1  1 = write, 0 = read
host_addr  in  4  host register address
host_wdata  in  8  host write data
host_ack  out  1  one-cycle completion pulse
host_rdata  out  8  read data, valid while host_ack = 1
host_err  out  1  completion was a timeout (0 when the optional feature is off)
host_busy  out  1  host transaction accepted and not yet acked
core_addr  out  4  register address to the core
core_wdata  out  8  write data to the core
core_rd  out  1  read enable
core_we  out  1  write enable
core_commit  out  1  one-cycle write-commit strobe
core_rdata  in  8  addressed register value from the core

Behaviour:
Reset: all outputs 0; FSM = IDLE; last_low = 0, so no host access occurs until one full low phase has been measured.

Phase measurement:
- phi2_q is phi2 registered; phi2_up and phi2_dn are its edges.
- low_cnt is 0 in the first phi2_q-low cycle and increments each cycle, saturating at 255.
- On phi2_up, last_low <= low_cnt + 1 (saturating at 255).

Bus path:
- Active while phi2_q = 1, or while phi2_q = 0 and the FSM is IDLE.
- core_addr = bus_addr, core_wdata = bus_wdata.
- core_rd = phi2_q & ~cs_n & r_w_n; core_we = phi2_q & ~cs_n & ~r_w_n.
- core_commit = phi2_dn & (bus write was active in the previous cycle).

Host window:
- Condition: phi2_q = 0, last_low ≥ MIN_LOW, and low_cnt + 3 + GUARD_CYCLES ≤ last_low.

FSM:
- IDLE: if host_req and window → SETUP; latch host_we, host_addr, host_wdata; host_busy = 1.
- SETUP: drive core_addr/core_wdata from the latch with no strobe. If phi2_q = 1 → abort to IDLE; the request stays pending and retries in the next window. Otherwise → STROBE.
- STROBE: core_rd = ~we_l or core_we = we_l, for exactly one cycle; core_commit = we_l. Capture core_rdata into host_rdata. → ACK. Once STROBE is entered the access always completes.
- ACK: host_ack = 1 for one cycle; host_busy cleared → IDLE. A host_req still high in the cycle after ACK is treated as a new request.
- Exactly one core strobe per host transaction, so read side effects (e.g. ICR clear-on-read) happen once.
- Bus strobes and host strobes are never asserted in the same cycle.

Other rules:
- host_rdata holds its last value after ACK.
- Host inputs may change only after host_ack.
- If phi2 stops high, host requests wait indefinitely (unless the optional feature is on).
- Asynchronous reset mid-transaction: immediate return to reset state; no ack is issued; a host_req still high is restarted after reset release once a low phase has been measured.

Optional Feature:
CIA_HOST_ARB_TIMEOUT_EN
- With it: an 8-bit counter counts phi2_up edges while host_req is pending outside SETUP/STROBE/ACK. When it reaches TIMEOUT_PHI2: host_ack = 1, host_err = 1, host_rdata = 0xFF, no core strobe; the counter clears.
- Without it: counter absent, host_err tied to 0.

Decomposition:
Package cia:
- arb_state_t enum {IDLE, SETUP, STROBE, ACK}
- host_req_t struct {we, addr, wdata}
- HOST_ACCESS_CYCLES = 3

Sub-module cia_phi2_window: phi2 edge detection, low_cnt and last_low measurement, window output.

Test Plan:
1. Reset; phi2 10 clk high / 10 low; after one low phase, host write addr 0x4 data 0x5A at low_cnt 0 → SETUP at cnt 1, core_we = core_commit = 1 at cnt 2 with core_addr 0x4 and core_wdata 0x5A, host_ack at cnt 3, host_err 0.
2. Host read addr 0xD, core_rdata = 0x81 → exactly one core_rd pulse; host_rdata = 0x81 during host_ack.
3. Host request raised at low_cnt 6 (last_low 10, GUARD 2) → no strobe this phase; executes at low_cnt 0 of the next low phase.
4. Host request immediately after reset → nothing until the first low phase ends (last_low latched); the access then happens in the second low phase.
5. Bus write (cs_n = 0, r_w_n = 0, addr 0x6, data 0x33) with a concurrent host_req → core_we level during high, core_commit on phi2_dn with core_addr 0x6; the host access follows in the low phase with no strobe overlap.
6. rst_n low during STROBE → all outputs 0 in the same cycle, no ack. With CIA_HOST_ARB_TIMEOUT_EN, TIMEOUT_PHI2 = 4 and phi2 stuck toggling with a 3-cycle low phase → ack with host_err = 1, host_rdata 0xFF after the 4th phi2_up.
